// File: rtl/layer_seq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : layer_seq_arb
//  Purpose  : Runs NUM_ST stages in fixed order, lends the shared RAM ports to
//             the running stage, and guards each stage with a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module layer_seq_arb #(
   parameter int NUM_ST = 4,
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int TMO    = 65535
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_stage,
   output logic [NUM_ST-1:0]    st_start,
   input  logic [NUM_ST-1:0]    st_end,
   input  logic [NUM_ST-1:0]    st_rd_en,
   input  logic [NUM_ST*AW-1:0] st_rd_addr,
   input  logic [NUM_ST-1:0]    st_wr_en,
   input  logic [NUM_ST-1:0]    st_wr_we,
   input  logic [NUM_ST*AW-1:0] st_wr_addr,
   input  logic [NUM_ST*DW-1:0] st_wr_data,
   output logic                 ram_en_r,
   output logic [AW-1:0]        ram_addr_r,
   output logic                 ram_en,
   output logic                 ram_wea,
   output logic [AW-1:0]        ram_addr_w,
   output logic [DW-1:0]        ram_data_w,
   output logic [1:0]           cur_stage
);

   localparam int                c_WW   = $clog2(TMO + 1);
   localparam logic [c_WW-1:0]   c_TMO  = c_WW'(TMO);
   localparam logic [1:0]        c_LAST = 2'(NUM_ST - 1);
   localparam logic [NUM_ST-1:0] c_ONE  = NUM_ST'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_GAP    = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t            r_state;
   logic [1:0]        r_cur;
   logic [1:0]        r_err_stage;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_end_q;
   logic [NUM_ST-1:0] r_st_start;
   logic [c_WW-1:0]   r_wdog;

   logic [AW-1:0]     w_rd_addr [NUM_ST];
   logic [AW-1:0]     w_wr_addr [NUM_ST];
   logic [DW-1:0]     w_wr_data [NUM_ST];
   logic              w_own;
   logic              w_end_cur;
   logic              w_rise;
   logic [c_WW-1:0]   w_wdog_nxt;

   for (genvar i = 0; i < NUM_ST; i++) begin : g_unpack
      assign w_rd_addr[i] = st_rd_addr[i*AW +: AW];
      assign w_wr_addr[i] = st_wr_addr[i*AW +: AW];
      assign w_wr_data[i] = st_wr_data[i*DW +: DW];
   end

   assign w_end_cur  = st_end[r_cur];
   assign w_rise     = w_end_cur & ~r_end_q;
   assign w_wdog_nxt = (r_wdog == c_TMO) ? c_TMO : r_wdog + c_WW'(1);

   // Only the owning stage reaches the RAM, and only while it is running.
   assign w_own      = (r_state == S_LAUNCH) || (r_state == S_WAIT);
   assign ram_en_r   = w_own & st_rd_en[r_cur];
   assign ram_addr_r = w_own ? w_rd_addr[r_cur] : '0;
   assign ram_en     = w_own & st_wr_en[r_cur];
   assign ram_wea    = w_own & st_wr_we[r_cur];
   assign ram_addr_w = w_own ? w_wr_addr[r_cur] : '0;
   assign ram_data_w = w_own ? w_wr_data[r_cur] : '0;

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign err_stage = r_err_stage;
   assign st_start  = r_st_start;
   assign cur_stage = r_cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur       <= '0;
         r_err_stage <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_end_q     <= 1'b0;
         r_st_start  <= '0;
         r_wdog      <= '0;
      end else begin
         r_done     <= 1'b0;
         r_st_start <= '0;
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_err      <= 1'b0;
                  r_cur      <= '0;
                  r_busy     <= 1'b1;
                  r_end_q    <= 1'b0;
                  r_st_start <= c_ONE;
                  r_state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_end_q <= w_end_cur;
               r_wdog  <= w_wdog_nxt;
               // Completion is checked first so it wins a same-cycle expiry.
               if (w_rise) begin
                  if (r_cur == c_LAST) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_GAP;
                  end
               end else if (w_wdog_nxt == c_TMO) begin
                  r_err       <= 1'b1;
                  r_err_stage <= r_cur;
                  r_state     <= S_ERR;
               end
            end
            S_GAP: begin
               r_cur      <= r_cur + 2'd1;
               r_end_q    <= 1'b0;
               r_st_start <= c_ONE << (r_cur + 2'd1);
               r_state    <= S_LAUNCH;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_ERR: begin
               if (go) begin
                  r_err   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_seq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_seq_arb
//  Purpose  : Scripted runs of layer_seq_arb; an event scoreboard checks the
//             start/done/error pulses and their cycle numbers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_seq_arb;

   localparam int NUM_ST = 4;
   localparam int AW     = 16;
   localparam int DW     = 8;
   localparam int TMO    = 50;

   localparam int EV_START = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int kind;
      int data;
      int cyc;
   } ev_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 go;
   logic                 busy, done, err;
   logic [1:0]           err_stage, cur_stage;
   logic [NUM_ST-1:0]    st_start, st_end, st_rd_en, st_wr_en, st_wr_we;
   logic [NUM_ST*AW-1:0] st_rd_addr, st_wr_addr;
   logic [NUM_ST*DW-1:0] st_wr_data;
   logic                 ram_en_r, ram_en, ram_wea;
   logic [AW-1:0]        ram_addr_r, ram_addr_w;
   logic [DW-1:0]        ram_data_w;

   int  cyc = 0;
   int  t0  = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   logic err_q = 1'b0;
   ev_t exp_q[$];

   layer_seq_arb #(.NUM_ST(NUM_ST), .AW(AW), .DW(DW), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done), .err(err),
      .err_stage(err_stage), .st_start(st_start), .st_end(st_end),
      .st_rd_en(st_rd_en), .st_rd_addr(st_rd_addr), .st_wr_en(st_wr_en),
      .st_wr_we(st_wr_we), .st_wr_addr(st_wr_addr), .st_wr_data(st_wr_data),
      .ram_en_r(ram_en_r), .ram_addr_r(ram_addr_r), .ram_en(ram_en),
      .ram_wea(ram_wea), .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w),
      .cur_stage(cur_stage)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < t0 + n) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   task automatic push(input int kind, input int data, input int rel);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = t0 + rel;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int data);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL unexpected_event: got kind=%0d data=%0d cyc=%0d, none expected", kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.data != data || e.cyc != cyc) begin
            n_errors++;
            $display("FAIL event: got kind=%0d data=%0d cyc=%0d expected kind=%0d data=%0d cyc=%0d",
                     kind, data, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      int idx;
      if (|st_start) begin
         idx = -1;
         if ($countones(st_start) == 1)
            for (int i = 0; i < NUM_ST; i++) if (st_start[i]) idx = i;
         observe(EV_START, idx);
      end
      if (done) observe(EV_DONE, 0);
      if (err && !err_q) observe(EV_ERR, int'(err_stage));
      err_q = err;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      go         = 1'b0;
      st_end     = '0;
      st_rd_en   = 4'b1111;
      st_wr_en   = 4'b1111;
      st_wr_we   = 4'b1111;
      st_rd_addr = {16'h0333, 16'h0222, 16'h0123, 16'h0456};
      st_wr_addr = {16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA};
      st_wr_data = {8'h33, 8'h22, 8'hA5, 8'h5A};

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_stage", err_stage, 0);
      chk("rst_st_start", st_start, 0);
      chk("rst_cur_stage", cur_stage, 0);
      chk("rst_ram_en_r", ram_en_r, 0);
      chk("rst_ram_addr_r", ram_addr_r, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_wea", ram_wea, 0);
      chk("rst_ram_addr_w", ram_addr_w, 0);
      chk("rst_ram_data_w", ram_data_w, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_ram_en_r", ram_en_r, 0);

      // Run 1: nominal sequence, ownership mux, held end, stray inputs.
      tick(); go = 1'b1; t0 = cyc;
      push(EV_START, 0, 1);
      push(EV_START, 1, 23);
      push(EV_START, 2, 45);
      push(EV_START, 3, 67);
      push(EV_DONE, 0, 88);
      goto(1);  go = 1'b0;
      chk("r1_cur0", cur_stage, 0);
      chk("r1_busy", busy, 1);
      chk("r1_ram_en_r", ram_en_r, 1);
      chk("r1_addr_r_s0", ram_addr_r, 16'h0456);
      goto(10);
      chk("r1_addr_w_s0", ram_addr_w, 16'h0AAA);
      chk("r1_data_w_s0", ram_data_w, 8'h5A);
      chk("r1_ram_en", ram_en, 1);
      chk("r1_ram_wea", ram_wea, 1);
      goto(21); st_end[0] = 1'b1;
      goto(22);
      chk("gap_ram_en_r", ram_en_r, 0);
      chk("gap_ram_en", ram_en, 0);
      chk("gap_ram_wea", ram_wea, 0);
      chk("gap_addr_r", ram_addr_r, 0);
      chk("gap_data_w", ram_data_w, 0);
      goto(23);
      chk("r1_addr_r_s1", ram_addr_r, 16'h0123);
      chk("r1_cur1", cur_stage, 1);
      goto(25); st_end[0] = 1'b0;
      goto(30); st_end[3] = 1'b1;
      goto(31); st_end[3] = 1'b0;
      goto(35); go = 1'b1;
      goto(36); go = 1'b0;
      goto(43); st_end[1] = 1'b1;
      goto(47); st_end[1] = 1'b0;
      goto(65); st_end[2] = 1'b1;
      goto(75); st_end[2] = 1'b0;
      goto(87); st_end[3] = 1'b1;
      goto(88); chk("r1_busy_done", busy, 1);
      goto(89);
      chk("r1_busy_after", busy, 0);
      chk("r1_done_after", done, 0);
      goto(91); st_end[3] = 1'b0;
      goto(95);

      // Run 2: stage 1 never ends; watchdog fires after 50 WAIT cycles.
      tick(); go = 1'b1; t0 = cyc;
      push(EV_START, 0, 1);
      push(EV_START, 1, 23);
      push(EV_ERR, 1, 74);
      goto(1);  go = 1'b0;
      goto(21); st_end[0] = 1'b1;
      goto(22); st_end[0] = 1'b0;
      goto(73); chk("to_err_before", err, 0);
      goto(74);
      chk("to_err", err, 1);
      chk("to_err_stage", err_stage, 1);
      chk("to_busy", busy, 1);
      chk("to_ram_en_r", ram_en_r, 0);
      chk("to_ram_en", ram_en, 0);
      chk("to_addr_r", ram_addr_r, 0);
      goto(80); chk("to_busy_hold", busy, 1);
      goto(85); go = 1'b1;
      goto(86); go = 1'b0;
      chk("to_err_clr", err, 0);
      chk("to_busy_clr", busy, 0);
      goto(90);

      // Run 3: completion meets expiry on the same cycle, then reset mid-run.
      tick(); go = 1'b1; t0 = cyc;
      push(EV_START, 0, 1);
      push(EV_START, 1, 53);
      push(EV_START, 2, 75);
      goto(1);  go = 1'b0;
      goto(51); st_end[0] = 1'b1;
      goto(52); st_end[0] = 1'b0;
      chk("col_err", err, 0);
      goto(53); chk("col_cur1", cur_stage, 1);
      goto(73); st_end[1] = 1'b1;
      goto(74); st_end[1] = 1'b0;
      goto(75); chk("col_cur2", cur_stage, 2);
      goto(80); rst_n = 1'b0; #1;
      chk("ar_busy", busy, 0);
      chk("ar_cur", cur_stage, 0);
      chk("ar_ram_en_r", ram_en_r, 0);
      chk("ar_addr_r", ram_addr_r, 0);
      chk("ar_ram_en", ram_en, 0);
      chk("ar_done", done, 0);
      goto(83); rst_n = 1'b1;
      goto(95); chk("ar_idle_busy", busy, 0);

      // Run 4: fresh go after reset starts again at stage 0.
      tick(); go = 1'b1; t0 = cyc;
      push(EV_START, 0, 1);
      push(EV_START, 1, 6);
      push(EV_START, 2, 11);
      push(EV_START, 3, 16);
      push(EV_DONE, 0, 20);
      goto(1);  go = 1'b0;
      chk("r4_cur0", cur_stage, 0);
      goto(4);  st_end[0] = 1'b1;
      goto(5);  st_end[0] = 1'b0;
      chk("r4_gap_en_r", ram_en_r, 0);
      goto(9);  st_end[1] = 1'b1;
      goto(10); st_end[1] = 1'b0;
      goto(12);
      chk("r4_data_w_s2", ram_data_w, 8'h22);
      chk("r4_addr_w_s2", ram_addr_w, 16'h0CCC);
      goto(14); st_end[2] = 1'b1;
      goto(15); st_end[2] = 1'b0;
      goto(17);
      chk("r4_addr_r_s3", ram_addr_r, 16'h0333);
      chk("r4_cur3", cur_stage, 3);
      goto(19); st_end[3] = 1'b1;
      goto(20); st_end[3] = 1'b0;
      chk("r4_done", done, 1);
      goto(21);
      chk("r4_done_off", done, 0);
      chk("r4_busy_off", busy, 0);
      goto(30);

      chk("events_pending", exp_q.size(), 0);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         $display("FAIL missing_event: kind=%0d data=%0d cyc=%0d never seen", e.kind, e.data, e.cyc);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
